// File: rtl/wiper_pkg.sv
// Shared types and default timing constants for the wiper motor controller.
// The optional single-wipe input is enabled with WIPER_SINGLE_WIPE_EN.
package wiper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT,
        ST_BACK,
        ST_PAUSE,
        ST_FAULT
    } wiper_state_e;

    localparam int DEF_CNT_W           = 16;
    localparam int DEF_SWEEP_CYCLES    = 1000;
    localparam int DEF_INTERVAL_CYCLES = 4000;
    localparam int DEF_TIMEOUT_CYCLES  = 3000;

    // States in which the motor is energised.
    function automatic logic is_drive_state(wiper_state_e s);
        return (s == ST_OUT) || (s == ST_BACK);
    endfunction

    function automatic logic is_busy_state(wiper_state_e s);
        return (s == ST_OUT) || (s == ST_BACK) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/wiper_motor_ctrl_if.sv
// Request/motor-drive bundle between the wiper decision logic and the motor controller.
// single_wipe exists only when WIPER_SINGLE_WIPE_EN is defined.
interface wiper_motor_ctrl_if;

    logic wiper_req;
    logic fast;
    logic park_sw;
`ifdef WIPER_SINGLE_WIPE_EN
    logic single_wipe;
`endif
    logic motor_on;
    logic motor_dir;
    logic motor_fast;
    logic busy;
    logic fault;

    modport master (
`ifdef WIPER_SINGLE_WIPE_EN
        output single_wipe,
`endif
        output wiper_req,
        output fast,
        output park_sw,
        input  motor_on,
        input  motor_dir,
        input  motor_fast,
        input  busy,
        input  fault
    );

    modport slave (
`ifdef WIPER_SINGLE_WIPE_EN
        input  single_wipe,
`endif
        input  wiper_req,
        input  fast,
        input  park_sw,
        output motor_on,
        output motor_dir,
        output motor_fast,
        output busy,
        output fault
    );

endinterface

// File: rtl/wiper_timer.sv
// Shared cycle counter: clears on clr, counts while en, done when count == cmp-1.
module wiper_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == (cmp - CNT_W'(1)));

endmodule

// File: rtl/wiper_motor_ctrl.sv
// Wiper motor sequencer: outward stroke, return to park, optional pause, park-timeout fault.
// Define WIPER_SINGLE_WIPE_EN to add the single_wipe one-shot trigger.
module wiper_motor_ctrl
    import wiper_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int SWEEP_CYCLES    = DEF_SWEEP_CYCLES,
    parameter int INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    wiper_motor_ctrl_if.slave  bus
);

    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    if (SWEEP_CYCLES < 2 || longint'(SWEEP_CYCLES) >= CNT_LIMIT) begin : g_bad_sweep
        $error("SWEEP_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (INTERVAL_CYCLES < 2 || longint'(INTERVAL_CYCLES) >= CNT_LIMIT) begin : g_bad_interval
        $error("INTERVAL_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (TIMEOUT_CYCLES < 2 || longint'(TIMEOUT_CYCLES) >= CNT_LIMIT) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    wiper_state_e     state, state_next;
    logic             timer_clr, timer_en, timer_done;
    logic [CNT_W-1:0] timer_cmp;
    logic             latch_fast;
    logic             sw_rise;

    logic motor_on_q, motor_dir_q, motor_fast_q, busy_q, fault_q;

`ifdef WIPER_SINGLE_WIPE_EN
    logic sw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q <= 1'b0;
        end else begin
            sw_q <= bus.single_wipe;
        end
    end

    assign sw_rise = bus.single_wipe & ~sw_q;
`else
    assign sw_rise = 1'b0;
`endif

    wiper_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .cmp  (timer_cmp),
        .done (timer_done)
    );

    // NOTE: every signal driven here gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        timer_cmp  = CNT_W'(SWEEP_CYCLES);
        timer_en   = 1'b0;
        latch_fast = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.wiper_req || sw_rise) begin
                    state_next = ST_OUT;
                    latch_fast = 1'b1;
                end
            end
            ST_OUT: begin
                timer_en  = 1'b1;
                timer_cmp = CNT_W'(SWEEP_CYCLES);
                if (timer_done) begin
                    state_next = ST_BACK;
                end
            end
            ST_BACK: begin
                timer_en  = 1'b1;
                timer_cmp = CNT_W'(TIMEOUT_CYCLES);
                // Reaching park outranks a timeout landing on the same cycle.
                if (bus.park_sw) begin
                    if (!bus.wiper_req) begin
                        state_next = ST_IDLE;
                    end else if (bus.fast) begin
                        state_next = ST_OUT;
                        latch_fast = 1'b1;
                    end else begin
                        state_next = ST_PAUSE;
                    end
                end else if (timer_done) begin
                    state_next = ST_FAULT;
                end
            end
            ST_PAUSE: begin
                timer_en  = 1'b1;
                timer_cmp = CNT_W'(INTERVAL_CYCLES);
                if (!bus.wiper_req) begin
                    state_next = ST_IDLE;
                end else if (bus.fast || timer_done) begin
                    state_next = ST_OUT;
                    latch_fast = 1'b1;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every state change restarts the shared counter from zero.
        timer_clr = (state_next != state);
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            motor_on_q   <= 1'b0;
            motor_dir_q  <= 1'b0;
            motor_fast_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state       <= state_next;
            motor_on_q  <= is_drive_state(state_next);
            motor_dir_q <= (state_next == ST_OUT);
            busy_q      <= is_busy_state(state_next);
            fault_q     <= (state_next == ST_FAULT);
            if (latch_fast) begin
                motor_fast_q <= bus.fast;
            end
        end
    end

    assign bus.motor_on   = motor_on_q;
    assign bus.motor_dir  = motor_dir_q;
    assign bus.motor_fast = motor_fast_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_wiper_motor_ctrl.sv
// Directed and randomized bench for wiper_motor_ctrl against a phase/elapsed-time model.
module tb_wiper_motor_ctrl;

    localparam int SWEEP    = 4;
    localparam int INTERVAL = 8;
    localparam int TIMEOUT  = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wiper_motor_ctrl_if bus ();

    wiper_motor_ctrl #(
        .CNT_W           (16),
        .SWEEP_CYCLES    (SWEEP),
        .INTERVAL_CYCLES (INTERVAL),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: which part of the wipe cycle we are in and how many cycles it has lasted.
    typedef enum {P_IDLE, P_SWEEP, P_RETURN, P_WAIT, P_DEAD} phase_e;

    phase_e ph       = P_IDLE;
    int     elapsed  = 0;
    logic   m_fast   = 1'b0;
    logic   prev_sw  = 1'b0;
    int     park_at  = -1;   // >=0: park on that return cycle, -1: never, -2: random
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic start_sweep();
        ph      = P_SWEEP;
        elapsed = 0;
        m_fast  = bus.fast;
    endtask

    // Apply the specification rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic rise;
        rise = 1'b0;
        if (rst) begin
            ph = P_IDLE; elapsed = 0; m_fast = 1'b0; prev_sw = 1'b0;
            return;
        end
`ifdef WIPER_SINGLE_WIPE_EN
        rise    = bus.single_wipe && !prev_sw;
        prev_sw = bus.single_wipe;
`endif
        case (ph)
            P_IDLE: if (bus.wiper_req || rise) start_sweep();
            P_SWEEP: begin
                elapsed++;
                if (elapsed == SWEEP) begin ph = P_RETURN; elapsed = 0; end
            end
            P_RETURN: begin
                elapsed++;
                if (bus.park_sw) begin
                    if (!bus.wiper_req) begin ph = P_IDLE; elapsed = 0; end
                    else if (bus.fast) start_sweep();
                    else begin ph = P_WAIT; elapsed = 0; end
                end else if (elapsed == TIMEOUT) begin
                    ph = P_DEAD;
                end
            end
            P_WAIT: begin
                elapsed++;
                if (!bus.wiper_req) begin ph = P_IDLE; elapsed = 0; end
                else if (bus.fast || elapsed == INTERVAL) start_sweep();
            end
            default: ph = P_DEAD;
        endcase
    endtask

    task automatic step(string tag);
        logic exp_on;
        @(posedge clk);
        model_edge();
        #1;
        exp_on = (ph == P_SWEEP) || (ph == P_RETURN);
        check({tag, ".motor_on"},  bus.motor_on,  exp_on);
        check({tag, ".motor_dir"}, bus.motor_dir, ph == P_SWEEP);
        check({tag, ".busy"},      bus.busy,      exp_on || (ph == P_WAIT));
        check({tag, ".fault"},     bus.fault,     ph == P_DEAD);
        if (exp_on) check({tag, ".motor_fast"}, bus.motor_fast, m_fast);
        if (park_at >= 0)       bus.park_sw = (ph == P_RETURN) && (elapsed == park_at);
        else if (park_at == -2) bus.park_sw = ($urandom_range(0, 3) == 0);
        else                    bus.park_sw = 1'b0;
    endtask

    initial begin
        int pauses;
        logic raised;

        rst           = 1'b1;
        bus.wiper_req = 1'b0;
        bus.fast      = 1'b0;
        bus.park_sw   = 1'b0;
`ifdef WIPER_SINGLE_WIPE_EN
        bus.single_wipe = 1'b0;
`endif

        // Reset and idle
        step("reset"); step("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step("idle");

        // Fast continuous wiping, park reached on the third return cycle
        park_at = 2; bus.wiper_req = 1'b1; bus.fast = 1'b1;
        for (int i = 0; i < 24; i++) step("fast");
        bus.wiper_req = 1'b0;
        for (int i = 0; i < 10; i++) step("fast_stop");

        // Intermittent: one full pause, then fast raised on pause cycle 3
        bus.wiper_req = 1'b1; bus.fast = 1'b0;
        pauses = 0; raised = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ph == P_WAIT && elapsed == 0) pauses++;
            if (!raised && pauses == 2 && ph == P_WAIT && elapsed == 3) begin
                bus.fast = 1'b1; raised = 1'b1;
            end
            step("interm");
        end
        bus.wiper_req = 1'b0; bus.fast = 1'b0;
        for (int i = 0; i < 12; i++) step("interm_stop");

        // Request drops at outward cycle 1: stroke still completes
        park_at = 3; bus.wiper_req = 1'b1;
        for (int i = 0; i < 5 && !(ph == P_SWEEP && elapsed == 1); i++) step("drop_start");
        bus.wiper_req = 1'b0;
        for (int i = 0; i < 16; i++) step("drop");

        // Park switch never closes: timeout fault, sticky until reset
        park_at = -1; bus.wiper_req = 1'b1;
        for (int i = 0; i < 14; i++) step("timeout");
        for (int i = 0; i < 10; i++) begin
            bus.wiper_req = ~bus.wiper_req;
            step("fault_hold");
        end
        rst = 1'b1; step("fault_rst");
        rst = 1'b0; bus.wiper_req = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst");

        // Park lands on the timeout cycle: no fault
        park_at = 5; bus.wiper_req = 1'b1; bus.fast = 1'b1;
        for (int i = 0; i < 16; i++) step("coincide");
        bus.wiper_req = 1'b0;
        for (int i = 0; i < 12; i++) step("coincide_stop");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) bus.wiper_req = ~bus.wiper_req;
            if ($urandom_range(0, 7) == 0) bus.fast = ~bus.fast;
            park_at = ($urandom_range(0, 1) == 0) ? -2 : int'($urandom_range(0, 5));
`ifdef WIPER_SINGLE_WIPE_EN
            bus.single_wipe = ($urandom_range(0, 5) == 0);
`endif
            rst = (ph == P_DEAD && $urandom_range(0, 3) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
